// File: rtl/detector_jogada_if.sv
// ----------------------------------------------------------------------------
// detector_jogada_if
// Groups the button-side and control-side signals of detector_jogada.
//
// Signal semantics (there is no valid/ready pair on this block):
//   botoes        raw asynchronous buttons, active high (driven by master)
//   zera          synchronous clear of captured code and FSM (driven by master)
//   jogada        single-cycle strobe, one per accepted press; the consumer
//                 must act on the cycle it is high, there is no back-pressure
//   jogada_codigo one-hot code of the last accepted press, valid from the edge
//                 jogada rises and held until next press, zera or reset
//   db_estado     current FSM state code, for debug
//
// Modports:
//   master : the environment (drives botoes/zera, observes outputs)
//   slave  : the detector itself
// ----------------------------------------------------------------------------
interface detector_jogada_if #(
  parameter int N_BOTOES = 4
);
  logic [N_BOTOES-1:0] botoes;
  logic                zera;
  logic                jogada;
  logic [N_BOTOES-1:0] jogada_codigo;
  logic [2:0]          db_estado;

  modport master (
    output botoes, zera,
    input  jogada, jogada_codigo, db_estado
  );

  modport slave (
    input  botoes, zera,
    output jogada, jogada_codigo, db_estado
  );
endinterface

// File: rtl/detector_jogada.sv
// ----------------------------------------------------------------------------
// detector_jogada
// Input stage of the game control unit: synchronizes and debounces raw player
// buttons, rejects multi-button presses, and emits exactly one single-cycle
// jogada pulse per valid press with a held one-hot code of the button.
//
// Ports:
//   clock  rising-edge clock, single domain
//   reset  asynchronous, active-low; clears all state and outputs
//   bus    detector_jogada_if.slave (botoes, zera in; jogada,
//          jogada_codigo, db_estado out)
//
// Parameters:
//   N_BOTOES        number of buttons (must match the interface width)
//   DEBOUNCE_CICLOS stable-sample count to accept a press (>= 2)
//
// Optional feature macro: DETECTOR_JOGADA_RELEASE_DEBOUNCE_EN
//   defined   : release is debounced in LIBERANDO before returning to OCIOSO
//   undefined : SEGURANDO returns straight to OCIOSO once the buttons read 0
// ----------------------------------------------------------------------------
module detector_jogada #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 1000
) (
  input  logic              clock,
  input  logic              reset,
  detector_jogada_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    FILTRANDO = 3'd1,
    PULSO     = 3'd2,
    SEGURANDO = 3'd3,
    LIBERANDO = 3'd4
  } estado_t;

  logic [N_BOTOES-1:0] sync1_q;
  logic [N_BOTOES-1:0] s_q;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] codigo_q, codigo_d;
  logic [CW-1:0]       cont_q, cont_d;
  estado_t             estado_q, estado_d;
  logic                jogada_q, jogada_d;

  logic s_zero;
  logic s_onehot;

  assign s_zero   = (s_q == '0);
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign s_onehot = !s_zero && ((s_q & (s_q - N_BOTOES'(1))) == '0);

  always_comb begin
    estado_d = estado_q;
    cand_d   = cand_q;
    cont_d   = cont_q;
    codigo_d = codigo_q;

    if (bus.zera) begin
      codigo_d = '0;
      cont_d   = '0;
      estado_d = s_zero ? OCIOSO : SEGURANDO;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          if (s_onehot) begin
            cand_d   = s_q;
            cont_d   = '0;
            estado_d = FILTRANDO;
          end else if (!s_zero) begin
            cont_d   = '0;
            estado_d = SEGURANDO;
          end
        end
        FILTRANDO: begin
          if (s_q == cand_q) begin
            if (cont_q == CONT_MAX) begin
              // The code is loaded on the same edge the pulse starts.
              codigo_d = cand_q;
              cont_d   = '0;
              estado_d = PULSO;
            end else begin
              cont_d = cont_q + CW'(1);
            end
          end else if (s_onehot) begin
            cand_d = s_q;
            cont_d = '0;
          end else if (s_zero) begin
            cont_d   = '0;
            estado_d = OCIOSO;
          end else begin
            cont_d   = '0;
            estado_d = SEGURANDO;
          end
        end
        PULSO: begin
          cont_d   = '0;
          estado_d = SEGURANDO;
        end
        SEGURANDO: begin
          if (s_zero) begin
            cont_d = '0;
`ifdef DETECTOR_JOGADA_RELEASE_DEBOUNCE_EN
            estado_d = LIBERANDO;
`else
            estado_d = OCIOSO;
`endif
          end
        end
`ifdef DETECTOR_JOGADA_RELEASE_DEBOUNCE_EN
        LIBERANDO: begin
          if (!s_zero) begin
            cont_d   = '0;
            estado_d = SEGURANDO;
          end else if (cont_q == CONT_MAX) begin
            cont_d   = '0;
            estado_d = OCIOSO;
          end else begin
            cont_d = cont_q + CW'(1);
          end
        end
`endif
        default: begin
          cont_d   = '0;
          estado_d = OCIOSO;
        end
      endcase
    end

    // Registered strobe: high exactly while the state register holds PULSO,
    // so a zera on the would-be PULSO edge suppresses it.
    jogada_d = (estado_d == PULSO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      s_q      <= '0;
      cand_q   <= '0;
      codigo_q <= '0;
      cont_q   <= '0;
      estado_q <= OCIOSO;
      jogada_q <= 1'b0;
    end else begin
      sync1_q  <= bus.botoes;
      s_q      <= sync1_q;
      cand_q   <= cand_d;
      codigo_q <= codigo_d;
      cont_q   <= cont_d;
      estado_q <= estado_d;
      jogada_q <= jogada_d;
    end
  end

  assign bus.jogada        = jogada_q;
  assign bus.jogada_codigo = codigo_q;
  assign bus.db_estado     = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
module tb_detector_jogada;

  localparam int N = 4;
  localparam int D = 4;
  localparam int MAXV = 40;

  logic clock;
  logic reset;

  detector_jogada_if #(.N_BOTOES(N)) bus ();

  detector_jogada #(
    .N_BOTOES       (N),
    .DEBOUNCE_CICLOS(D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q[$];

  logic [N-1:0] stim [MAXV];
  logic         zst  [MAXV];
  logic         jog  [MAXV];
  logic [N-1:0] cod  [MAXV];
  logic [2:0]   est  [MAXV];
  int           n_pulses;
  int           first_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.botoes = '0;
    bus.zera   = 1'b0;
    reset      = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic clear_vec();
    for (int k = 0; k < MAXV; k++) begin
      stim[k] = '0;
      zst[k]  = 1'b0;
    end
  endtask

  // Entry k of the tables is applied before edge k and recorded #1 after it.
  task automatic run_vec(input int n);
    n_pulses    = 0;
    first_pulse = -1;
    for (int k = 0; k < n; k++) begin
      bus.botoes = stim[k];
      bus.zera   = zst[k];
      @(posedge clock);
      #1;
      jog[k] = bus.jogada;
      cod[k] = bus.jogada_codigo;
      est[k] = bus.db_estado;
      if (bus.jogada) begin
        n_pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
  endtask

  // ---------------- scoreboard: every pulse must match an expected code ----
  always @(negedge clock) begin
    if (bus.jogada) begin
      check("pulso_esperado", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("codigo_pulso", bus.jogada_codigo, exp_q.pop_front());
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bus.botoes = '0;
    bus.zera   = 1'b0;
    reset      = 1'b0;
    #2;
    check("reset_jogada", bus.jogada, 0);
    check("reset_codigo", bus.jogada_codigo, 0);
    check("reset_estado", bus.db_estado, 0);
    do_reset();

    // Clean press
    clear_vec();
    for (int k = 0; k < 20; k++) stim[k] = 4'b0100;
    exp_q.push_back(4'b0100);
    run_vec(20);
    check("limpo_npulsos", n_pulses, 1);
    check("limpo_borda", first_pulse, 6);
    check("limpo_codigo6", cod[6], 4'b0100);
    check("limpo_jog7", jog[7], 0);
    check("limpo_codigo19", cod[19], 4'b0100);
    check("limpo_estado19", est[19], 3);

    // Bounce: toggles for 10 cycles, last stable run starts at edge 8
    do_reset();
    clear_vec();
    for (int k = 0; k < 30; k++)
      stim[k] = (k >= 10 || ((k / 2) % 2) == 0) ? 4'b0010 : 4'b0000;
    exp_q.push_back(4'b0010);
    run_vec(30);
    check("ressalto_npulsos", n_pulses, 1);
    check("ressalto_borda", first_pulse, 14);
    check("ressalto_codigo", cod[29], 4'b0010);

    // Multi-button
    do_reset();
    clear_vec();
    for (int k = 0; k < 20; k++) stim[k] = 4'b0011;
    run_vec(20);
    check("multi_npulsos", n_pulses, 0);
    check("multi_codigo", cod[19], 0);
    check("multi_estado", est[19], 3);

    // Value change inside FILTRANDO: 1000 first sampled at edge 3
    do_reset();
    clear_vec();
    for (int k = 0; k < 20; k++) stim[k] = (k < 3) ? 4'b0001 : 4'b1000;
    exp_q.push_back(4'b1000);
    run_vec(20);
    check("troca_estado4", est[4], 1);
    check("troca_npulsos", n_pulses, 1);
    check("troca_borda", first_pulse, 9);
    check("troca_codigo", cod[9], 4'b1000);

    // zera on the PULSO edge (code 1000 still held from previous press)
    clear_vec();
    for (int k = 10; k < 30; k++) stim[k] = 4'b0100;
    zst[16] = 1'b1;
    run_vec(30);
    check("zera_codigo_antes", cod[15], 4'b1000);
    check("zera_npulsos", n_pulses, 0);
    check("zera_codigo", cod[16], 0);
    check("zera_estado16", est[16], 3);
    check("zera_estado29", est[29], 3);

    // Release path with a one-cycle glitch after release
    do_reset();
    clear_vec();
    for (int k = 0; k < 30; k++) stim[k] = (k < 10 || k == 13) ? 4'b0001 : 4'b0000;
    exp_q.push_back(4'b0001);
    run_vec(30);
    check("soltura_npulsos", n_pulses, 1);
    check("soltura_borda", first_pulse, 6);
    check("soltura_estado11", est[11], 3);
`ifdef DETECTOR_JOGADA_RELEASE_DEBOUNCE_EN
    check("soltura_estado12", est[12], 4);
    check("soltura_estado15", est[15], 3);
    check("soltura_estado16", est[16], 4);
    check("soltura_estado19", est[19], 4);
`else
    check("soltura_estado12", est[12], 0);
    check("soltura_estado15", est[15], 1);
    check("soltura_estado16", est[16], 0);
    check("soltura_estado19", est[19], 0);
`endif
    check("soltura_estado20", est[20], 0);

    // Reset mid-FILTRANDO, then held button is a new press after release
    do_reset();
    clear_vec();
    for (int k = 0; k < 10; k++) stim[k] = 4'b0100;
    exp_q.push_back(4'b0100);
    run_vec(20);
    clear_vec();
    for (int k = 0; k < 3; k++) stim[k] = 4'b0001;
    run_vec(3);
    check("rst_pre_estado", est[2], 1);
    check("rst_pre_codigo", cod[2], 4'b0100);
    #3 reset = 1'b0;
    #1;
    check("rst_async_jogada", bus.jogada, 0);
    check("rst_async_codigo", bus.jogada_codigo, 0);
    check("rst_async_estado", bus.db_estado, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    clear_vec();
    for (int k = 0; k < 12; k++) stim[k] = 4'b0001;
    exp_q.push_back(4'b0001);
    run_vec(12);
    check("rst_nova_npulsos", n_pulses, 1);
    check("rst_nova_borda", first_pulse, 6);
    check("rst_nova_codigo", cod[11], 4'b0001);

    @(negedge clock);
    check("fila_vazia", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
